// File: rtl/knn_sched.sv
// knn_sched: scan sequencer for the KNN squared-distance datapath.
// Fetches up to N_MAX training points, computes each point's squared
// distance to a latched test point and keeps a sorted list of the K nearest.
// Optional build macro: KNN_PIPE_EN adds an SQ state that registers the two
// squares before CALC sums them (one extra cycle per point).
module knn_sched #(
    parameter int N_MAX   = 16,
    parameter int K       = 4,
    parameter int LABEL_W = 8,
    localparam int ADDR_W = $clog2(N_MAX),
    localparam int SEL_W  = (K > 1) ? $clog2(K) : 1,
    localparam int CNT_W  = $clog2(K + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W:0]    n_points,
    input  logic signed [15:0] test_x,
    input  logic signed [15:0] test_y,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic signed [15:0] mem_x,
    input  logic signed [15:0] mem_y,
    input  logic [LABEL_W-1:0] mem_label,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   count,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic [33:0]        rd_dist,
    output logic [LABEL_W-1:0] rd_label,
    output logic               rd_valid,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SQ     = 3'd2,
        CALC   = 3'd3,
        INSERT = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [ADDR_W:0]  N_MAX_L = (ADDR_W + 1)'(N_MAX);
    localparam logic [CNT_W-1:0] K_L     = CNT_W'(K);

    state_t               state;
    logic [ADDR_W:0]      n_r;
    logic [ADDR_W:0]      index;
    logic signed [15:0]   tx_r, ty_r;
    logic signed [15:0]   px_r, py_r;
    logic [LABEL_W-1:0]   plabel_r;
    logic [33:0]          new_dist;

    logic [33:0]          lst_dist  [K];
    logic [LABEL_W-1:0]   lst_label [K];
    logic                 lst_valid [K];
    logic [33:0]          nxt_dist  [K];
    logic [LABEL_W-1:0]   nxt_label [K];
    logic                 nxt_valid [K];

    logic [ADDR_W:0]      n_clamp;
    logic [ADDR_W:0]      idx_next;
    logic signed [16:0]   dx, dy;
    logic signed [33:0]   dx_w, dy_w;
    logic [33:0]          sq_x_c, sq_y_c;
    logic [33:0]          dist_c;

    assign n_clamp  = (n_points > N_MAX_L) ? N_MAX_L : n_points;
    assign idx_next = index + 1'b1;

    // Differences are 17-bit signed so the full 16-bit range cannot wrap;
    // each square fits in 32 bits, their sum in 33.
    assign dx     = 17'(px_r) - 17'(tx_r);
    assign dy     = 17'(py_r) - 17'(ty_r);
    assign dx_w   = 34'(dx);
    assign dy_w   = 34'(dy);
    assign sq_x_c = $unsigned(dx_w * dx_w);
    assign sq_y_c = $unsigned(dy_w * dy_w);

`ifdef KNN_PIPE_EN
    logic [33:0] sq_x_r, sq_y_r;

    // Square registers: split the multiply from the add for timing closure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sq_x_r <= '0;
            sq_y_r <= '0;
        end else if (state == SQ) begin
            sq_x_r <= sq_x_c;
            sq_y_r <= sq_y_c;
        end
    end

    assign dist_c = sq_x_r + sq_y_r;
`else
    assign dist_c = sq_x_c + sq_y_c;
`endif

    // Parallel compare-shift: strict < puts a tie after existing entries.
    always_comb begin
        nxt_dist  = lst_dist;
        nxt_label = lst_label;
        nxt_valid = lst_valid;
        if (new_dist < lst_dist[0]) begin
            nxt_dist[0]  = new_dist;
            nxt_label[0] = plabel_r;
            nxt_valid[0] = 1'b1;
        end
        for (int j = 1; j < K; j++) begin
            if (new_dist < lst_dist[j-1]) begin
                nxt_dist[j]  = lst_dist[j-1];
                nxt_label[j] = lst_label[j-1];
                nxt_valid[j] = lst_valid[j-1];
            end else if (new_dist < lst_dist[j]) begin
                nxt_dist[j]  = new_dist;
                nxt_label[j] = plabel_r;
                nxt_valid[j] = 1'b1;
            end
        end
    end

    // Memory handshake: mem_req rises with mem_addr when FETCH is entered and
    // both hold until a cycle with mem_ack high; that cycle's data is captured
    // and mem_req falls on the same edge. mem_ack is ignored outside FETCH.

    // Scan FSM: control outputs and the sorted list are all registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            count    <= '0;
            n_r      <= '0;
            index    <= '0;
            tx_r     <= '0;
            ty_r     <= '0;
            px_r     <= '0;
            py_r     <= '0;
            plabel_r <= '0;
            new_dist <= '0;
            for (int j = 0; j < K; j++) begin
                lst_dist[j]  <= '1;
                lst_label[j] <= '0;
                lst_valid[j] <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        tx_r  <= test_x;
                        ty_r  <= test_y;
                        n_r   <= n_clamp;
                        index <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        for (int j = 0; j < K; j++) begin
                            lst_dist[j]  <= '1;
                            lst_label[j] <= '0;
                            lst_valid[j] <= 1'b0;
                        end
                        if (n_clamp != '0) begin
                            state    <= FETCH;
                            mem_req  <= 1'b1;
                            mem_addr <= '0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        px_r     <= mem_x;
                        py_r     <= mem_y;
                        plabel_r <= mem_label;
                        mem_req  <= 1'b0;
`ifdef KNN_PIPE_EN
                        state    <= SQ;
`else
                        state    <= CALC;
`endif
                    end
                end
                SQ: begin
                    state <= CALC;
                end
                CALC: begin
                    new_dist <= dist_c;
                    state    <= INSERT;
                end
                INSERT: begin
                    lst_dist  <= nxt_dist;
                    lst_label <= nxt_label;
                    lst_valid <= nxt_valid;
                    index     <= idx_next;
                    if (count < K_L) count <= count + 1'b1;
                    if (idx_next == n_r) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= FETCH;
                        mem_req  <= 1'b1;
                        mem_addr <= idx_next[ADDR_W-1:0];
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_dist   = lst_dist[rd_sel];
    assign rd_label  = lst_label[rd_sel];
    assign rd_valid  = lst_valid[rd_sel];
    assign state_dbg = state;

endmodule

// File: tb/tb_knn_sched.sv
// Bench for knn_sched: memory responder with programmable ack delay, a
// handshake monitor, and a scoreboard of expected list entries per scan.
module tb_knn_sched;

  localparam int N_MAX = 16;
  localparam int K     = 4;
  localparam int EW    = 43;  // {valid, label[7:0], dist[33:0]}
`ifdef KNN_PIPE_EN
  localparam int PP = 4;
`else
  localparam int PP = 3;
`endif
  localparam logic [EW-1:0] EMPTY = {1'b0, 8'h00, 34'h3_FFFF_FFFF};

  logic               clk, rst, start;
  logic [4:0]         n_points;
  logic signed [15:0] test_x, test_y;
  logic               mem_req, mem_ack;
  logic [3:0]         mem_addr;
  logic signed [15:0] mem_x, mem_y;
  logic [7:0]         mem_label;
  logic               busy, done, rd_valid;
  logic [2:0]         count, state_dbg;
  logic [1:0]         rd_sel;
  logic [33:0]        rd_dist;
  logic [7:0]         rd_label;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0]      exp_q[$];
  logic signed [15:0] mx [N_MAX];
  logic signed [15:0] my [N_MAX];
  logic [7:0]         ml [N_MAX];
  int                 ack_delay = 0;
  int                 ack_cnt   = 0;
  bit                 spurious  = 0;
  int                 req_cycles = 0;
  int                 glitches   = 0;
  logic [3:0]         addr_log[$];
  logic               prev_req = 0;
  logic [3:0]         prev_addr = 0;

  knn_sched dut (
    .clk(clk), .rst(rst), .start(start), .n_points(n_points),
    .test_x(test_x), .test_y(test_y),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_x(mem_x), .mem_y(mem_y), .mem_label(mem_label),
    .busy(busy), .done(done), .count(count),
    .rd_sel(rd_sel), .rd_dist(rd_dist), .rd_label(rd_label),
    .rd_valid(rd_valid), .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // memory responder: acks after ack_delay request cycles, garbage otherwise
  initial begin
    mem_ack = 0; mem_x = 0; mem_y = 0; mem_label = 0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && ack_cnt == ack_delay) begin
        mem_ack = 1; mem_x = mx[mem_addr]; mem_y = my[mem_addr]; mem_label = ml[mem_addr];
        ack_cnt = 0;
      end else begin
        if (mem_req === 1'b1) begin
          ack_cnt++;
          mem_ack = 0;
        end else begin
          ack_cnt = 0;
          mem_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        mem_x = 16'($urandom); mem_y = 16'($urandom); mem_label = 8'($urandom);
      end
    end
  end

  // handshake monitor: request cycles, address changes under request, address order
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        req_cycles++;
        if (prev_req && mem_addr !== prev_addr) glitches++;
        if (!prev_req) addr_log.push_back(mem_addr);
      end
      prev_req = mem_req;
      prev_addr = mem_addr;
    end
  end

  // driver: pushes the expected list, runs one scan, returns the done cycle (-1 on timeout)
  task automatic drive_scan(input int n, input logic signed [15:0] tx, input logic signed [15:0] ty,
                            input int delay, input int pulse_cyc, output int done_cyc);
    logic [EW-1:0] lst [K];
    int ne, p, cyc;
    longint dx, dy, d;
    ne = (n > N_MAX) ? N_MAX : n;
    for (int j = 0; j < K; j++) lst[j] = EMPTY;
    for (int i = 0; i < ne; i++) begin
      dx = longint'(mx[i]) - longint'(tx);
      dy = longint'(my[i]) - longint'(ty);
      d = dx * dx + dy * dy;
      p = K;
      for (int j = K - 1; j >= 0; j--) if (34'(d) < lst[j][33:0]) p = j;
      if (p < K) begin
        for (int j = K - 1; j > p; j--) lst[j] = lst[j-1];
        lst[p] = {1'b1, ml[i], 34'(d)};
      end
    end
    for (int j = 0; j < K; j++) exp_q.push_back(lst[j]);
    ack_delay = delay; req_cycles = 0; glitches = 0; addr_log.delete();
    @(negedge clk);
    start = 1; n_points = 5'(n); test_x = tx; test_y = ty;
    @(posedge clk); #1;
    start = 0; test_x = 16'($urandom); test_y = 16'($urandom); n_points = 5'($urandom);
    cyc = 1; done_cyc = -1;
    while (cyc <= 600) begin
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      start = (cyc == pulse_cyc);
      @(posedge clk); #1;
      cyc++;
    end
    start = 0;
  endtask

  task automatic test_reset();
    rst = 0; start = 0; n_points = 0; test_x = 0; test_y = 0; rd_sel = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    checks++; if (mem_addr !== 4'd0) begin errors++; $display("FAIL reset_mem_addr got %0d exp 0", mem_addr); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    for (int j = 0; j < K; j++) begin
      rd_sel = 2'(j); #1;
      checks++;
      if ({rd_valid, rd_label, rd_dist} !== EMPTY) begin
        errors++; $display("FAIL reset_entry%0d got %h exp %h", j, {rd_valid, rd_label, rd_dist}, EMPTY);
      end
    end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_basic_sort();
    int dc;
    logic [EW-1:0] e;
    mx[0] = 3;  my[0] = 4;  ml[0] = 1;
    mx[1] = 1;  my[1] = 1;  ml[1] = 2;
    mx[2] = -2; my[2] = 0;  ml[2] = 3;
    mx[3] = 10; my[3] = 10; ml[3] = 4;
    mx[4] = 0;  my[4] = 1;  ml[4] = 5;
    drive_scan(5, 16'sd0, 16'sd0, 0, 0, dc);
    checks++; if (dc !== 5 * PP + 1) begin errors++; $display("FAIL basic_done_cycle got %0d exp %0d", dc, 5 * PP + 1); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL basic_count got %0d exp 4", count); end
    for (int j = 0; j < K; j++) begin
      rd_sel = 2'(j); #1;
      e = exp_q.pop_front();
      checks++;
      if ({rd_valid, rd_label, rd_dist} !== e) begin
        errors++; $display("FAIL basic_entry%0d got %h exp %h", j, {rd_valid, rd_label, rd_dist}, e);
      end
    end
    checks++; if (addr_log.size() !== 5) begin errors++; $display("FAIL basic_fetches got %0d exp 5", addr_log.size()); end
    for (int i = 0; i < addr_log.size(); i++) begin
      checks++;
      if (addr_log[i] !== 4'(i)) begin errors++; $display("FAIL basic_addr%0d got %0d exp %0d", i, addr_log[i], i); end
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_tie_short();
    int dc;
    logic [EW-1:0] e;
    mx[0] = 1; my[0] = 0; ml[0] = 7;
    mx[1] = 0; my[1] = 1; ml[1] = 9;
    drive_scan(2, 16'sd0, 16'sd0, 0, 0, dc);
    checks++; if (dc !== 2 * PP + 1) begin errors++; $display("FAIL tie_done_cycle got %0d exp %0d", dc, 2 * PP + 1); end
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL tie_count got %0d exp 2", count); end
    for (int j = 0; j < K; j++) begin
      rd_sel = 2'(j); #1;
      e = exp_q.pop_front();
      checks++;
      if ({rd_valid, rd_label, rd_dist} !== e) begin
        errors++; $display("FAIL tie_entry%0d got %h exp %h", j, {rd_valid, rd_label, rd_dist}, e);
      end
    end
  endtask

  task automatic test_extremes();
    int dc;
    logic [EW-1:0] e;
    mx[0] = 16'sh7FFF; my[0] = 16'sh7FFF; ml[0] = 8'hA5;
    drive_scan(1, -16'sd32768, -16'sd32768, 0, 0, dc);
    rd_sel = 0; #1;
    checks++; if (rd_dist !== 34'd8589672450) begin errors++; $display("FAIL extreme_dist got %0d exp 8589672450", rd_dist); end
    for (int j = 0; j < K; j++) begin
      rd_sel = 2'(j); #1;
      e = exp_q.pop_front();
      checks++;
      if ({rd_valid, rd_label, rd_dist} !== e) begin
        errors++; $display("FAIL extreme_entry%0d got %h exp %h", j, {rd_valid, rd_label, rd_dist}, e);
      end
    end
  endtask

  task automatic test_zero_points();
    int dc;
    logic [EW-1:0] e;
    drive_scan(0, 16'sd5, 16'sd5, 0, 0, dc);
    checks++; if (dc !== 1) begin errors++; $display("FAIL zero_done_cycle got %0d exp 1", dc); end
    checks++; if (req_cycles !== 0) begin errors++; $display("FAIL zero_mem_req got %0d cycles exp 0", req_cycles); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL zero_count got %0d exp 0", count); end
    for (int j = 0; j < K; j++) begin
      rd_sel = 2'(j); #1;
      e = exp_q.pop_front();
      checks++;
      if ({rd_valid, rd_label, rd_dist} !== e) begin
        errors++; $display("FAIL zero_entry%0d got %h exp %h", j, {rd_valid, rd_label, rd_dist}, e);
      end
    end
  endtask

  task automatic test_handshake();
    int dc;
    logic [EW-1:0] e;
    for (int i = 0; i < 3; i++) begin
      mx[i] = 16'($urandom_range(0, 2000)) - 16'sd1000;
      my[i] = 16'($urandom_range(0, 2000)) - 16'sd1000;
      ml[i] = 8'(20 + i);
    end
    drive_scan(3, 16'sd7, -16'sd3, 3, 0, dc);
    checks++; if (dc !== 3 * (PP + 3) + 1) begin errors++; $display("FAIL hs_done_cycle got %0d exp %0d", dc, 3 * (PP + 3) + 1); end
    checks++; if (req_cycles !== 12) begin errors++; $display("FAIL hs_req_cycles got %0d exp 12", req_cycles); end
    checks++; if (glitches !== 0) begin errors++; $display("FAIL hs_addr_stable got %0d changes exp 0", glitches); end
    checks++; if (addr_log.size() !== 3) begin errors++; $display("FAIL hs_fetches got %0d exp 3", addr_log.size()); end
    for (int j = 0; j < K; j++) begin
      rd_sel = 2'(j); #1;
      e = exp_q.pop_front();
      checks++;
      if ({rd_valid, rd_label, rd_dist} !== e) begin
        errors++; $display("FAIL hs_entry%0d got %h exp %h", j, {rd_valid, rd_label, rd_dist}, e);
      end
    end
  endtask

  task automatic test_start_busy();
    int dc;
    logic [EW-1:0] e;
    for (int i = 0; i < 4; i++) begin
      mx[i] = 16'(i * 3 - 4); my[i] = 16'(5 - i * 2); ml[i] = 8'(40 + i);
    end
    drive_scan(4, 16'sd1, 16'sd1, 0, 5, dc);
    checks++; if (dc !== 4 * PP + 1) begin errors++; $display("FAIL busy_start_done_cycle got %0d exp %0d", dc, 4 * PP + 1); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL busy_start_count got %0d exp 4", count); end
    for (int j = 0; j < K; j++) begin
      rd_sel = 2'(j); #1;
      e = exp_q.pop_front();
      checks++;
      if ({rd_valid, rd_label, rd_dist} !== e) begin
        errors++; $display("FAIL busy_start_entry%0d got %h exp %h", j, {rd_valid, rd_label, rd_dist}, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    int dc;
    logic [EW-1:0] e;
    mx[0] = 3;  my[0] = 4;  ml[0] = 1;
    mx[1] = 1;  my[1] = 1;  ml[1] = 2;
    mx[2] = -2; my[2] = 0;  ml[2] = 3;
    mx[3] = 10; my[3] = 10; ml[3] = 4;
    mx[4] = 0;  my[4] = 1;  ml[4] = 5;
    ack_delay = 0;
    @(negedge clk);
    start = 1; n_points = 5; test_x = 0; test_y = 0;
    @(posedge clk); #1;
    start = 0;
    repeat (3 * PP - 1) begin @(posedge clk); #1; end
    rst = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", count); end
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL midrst_mem_req got %b exp 0", mem_req); end
    checks++; if (mem_addr !== 4'd0) begin errors++; $display("FAIL midrst_mem_addr got %0d exp 0", mem_addr); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", done); end
    for (int j = 0; j < K; j++) begin
      rd_sel = 2'(j); #1;
      checks++;
      if ({rd_valid, rd_label, rd_dist} !== EMPTY) begin
        errors++; $display("FAIL midrst_entry%0d got %h exp %h", j, {rd_valid, rd_label, rd_dist}, EMPTY);
      end
    end
    @(negedge clk); rst = 1;
    drive_scan(5, 16'sd0, 16'sd0, 0, 0, dc);
    checks++; if (dc !== 5 * PP + 1) begin errors++; $display("FAIL midrst_rescan_cycle got %0d exp %0d", dc, 5 * PP + 1); end
    for (int j = 0; j < K; j++) begin
      rd_sel = 2'(j); #1;
      e = exp_q.pop_front();
      checks++;
      if ({rd_valid, rd_label, rd_dist} !== e) begin
        errors++; $display("FAIL midrst_entry_rescan%0d got %h exp %h", j, {rd_valid, rd_label, rd_dist}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dc, n, ne, dly, ec;
    logic signed [15:0] tx, ty;
    logic [EW-1:0] e;
    spurious = 1;
    for (int s = 0; s < 4; s++) begin
      n = (s == 0) ? 20 : $urandom_range(0, 20);
      ne = (n > N_MAX) ? N_MAX : n;
      dly = $urandom_range(0, 2);
      for (int i = 0; i < N_MAX; i++) begin
        mx[i] = 16'($urandom); my[i] = 16'($urandom); ml[i] = 8'($urandom);
      end
      if (N_MAX > 3) begin mx[3] = mx[1]; my[3] = my[1]; end
      tx = 16'($urandom); ty = 16'($urandom);
      drive_scan(n, tx, ty, dly, 0, dc);
      ec = (ne < K) ? ne : K;
      checks++; if (dc !== ne * (PP + dly) + 1) begin errors++; $display("FAIL b2b%0d_done_cycle got %0d exp %0d", s, dc, ne * (PP + dly) + 1); end
      checks++; if (count !== 3'(ec)) begin errors++; $display("FAIL b2b%0d_count got %0d exp %0d", s, count, ec); end
      for (int j = 0; j < K; j++) begin
        rd_sel = 2'(j); #1;
        e = exp_q.pop_front();
        checks++;
        if ({rd_valid, rd_label, rd_dist} !== e) begin
          errors++; $display("FAIL b2b%0d_entry%0d got %h exp %h", s, j, {rd_valid, rd_label, rd_dist}, e);
        end
      end
    end
    spurious = 0;
  endtask

  initial begin
    test_reset();
    test_basic_sort();
    test_tie_short();
    test_extremes();
    test_zero_points();
    test_handshake();
    test_start_busy();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/knn_sched.md
# knn_sched

Sequencer for the KNN squared-distance datapath. On `start` it walks up to `N_MAX` training points held in an external point memory and computes the squared Euclidean distance of each point to a latched test point. It keeps a sorted list of the `K` nearest points, with their labels, and raises `done` when the scan ends. It sits between the KNN register interface and the training-point memory.

## Interface
- `N_MAX`, 16: maximum number of training points; `ADDR_W = $clog2(N_MAX)`.
- `K`, 4: number of nearest neighbours kept (1..N_MAX).
- `LABEL_W`, 8: training-point label width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous reset, active-low.
- `start` in 1: begin a scan; sampled only in IDLE.
- `n_points` in ADDR_W+1: number of points to scan, sampled with `start`; clamped to `N_MAX`.
- `test_x`, `test_y` in 16: signed test point, sampled with `start`.
- `mem_req` out 1: point fetch request.
- `mem_addr` out ADDR_W: point index.
- `mem_ack` in 1: fetch complete; `mem_x`, `mem_y` and `mem_label` are valid this cycle.
- `mem_x`, `mem_y` in 16: signed training point.
- `mem_label` in LABEL_W: training label.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse at end of scan.
- `count` out $clog2(K+1): number of valid list entries, equal to min(n_points, K).
- `rd_sel` in $clog2(K): list entry select; 0 is the nearest entry.
- `rd_dist` out 34: squared distance of the selected entry (combinational read).
- `rd_label` out LABEL_W: label of the selected entry.
- `rd_valid` out 1: the selected entry holds a point.

## Operation
- States: IDLE, FETCH, CALC, INSERT, DONE. With `KNN_PIPE_EN` defined, SQ is added between FETCH and CALC.
- IDLE:
  - On `start`: latch `test_x`, `test_y` and the clamped `n_points`.
  - Clear the list: all entries get dist = 34'h3_FFFF_FFFF, label = 0, valid = 0. Set index = 0.
  - Go to FETCH if n > 0, else go to DONE.
- FETCH:
  - `mem_req` = 1 and `mem_addr` = index. Both are held stable until `mem_ack`.
  - On `mem_ack`: register x, y and label, then go to the next state.
  - If `mem_ack` is asserted in the first FETCH cycle, FETCH lasts one cycle.
- CALC:
  - dx = x − tx and dy = y − ty, each 17-bit signed.
  - dist = dx² + dy², 34-bit unsigned, registered.
  - No overflow is possible: the maximum is 2·65535² = 8 589 672 450.
- INSERT: parallel compare-shift in one cycle. For each entry j:
  - Entry j shifts from j−1 if new < d[j−1].
  - Entry j takes the new point if new < d[j] and (j = 0 or new ≥ d[j−1]).
  - Otherwise entry j is unchanged; an entry shifted out past K−1 is dropped.
  - Ties use strict `<`: an equal distance goes after existing entries, so the earlier index wins.
  - Then index++. Go to DONE if index = n, else go to FETCH.
- DONE: `done` = 1 for one cycle, then go to IDLE. The list and `count` hold until the next `start`.
- `start` while busy is ignored.
- `busy` = 1 in every state except IDLE.

## Timing
- Reset values:
  - Control outputs: `busy`, `done`, `mem_req` = 0; `mem_addr` = 0; `count` = 0.
  - List entries: dist all-ones, label 0, valid 0. Hence `rd_valid` = 0.
- With zero-wait `mem_ack`, each point takes 3 cycles (4 with `KNN_PIPE_EN`).
- `done` is high in cycle 3n+1 after the `start` edge (4n+1 with `KNN_PIPE_EN`). For n = 0, `done` is high 1 cycle after `start`.
- Each cycle `mem_ack` stays low adds one cycle to the point being fetched.
- `mem_ack` outside FETCH is ignored.
- Reset asserted mid-scan:
  - Immediately returns to IDLE, with every output and list entry at its reset value.
  - A fetch in flight is abandoned; the memory side must tolerate `mem_req` dropping without an ack.
- `rd_*` are combinational from the list registers. During a scan they show the partially built list.

## Configuration
- `KNN_PIPE_EN` defined:
  - SQ state registers dx² and dy² separately; CALC registers their sum.
  - Adds 1 cycle per point, for timing closure at high clock rates.
- `KNN_PIPE_EN` undefined: squares and sum are computed in the single CALC cycle.
- List results are identical in both builds.

## Test plan
- Basic sort: test (0,0), K = 4, zero-wait ack. Points: (3,4) L1, (1,1) L2, (−2,0) L3, (10,10) L4, (0,1) L5.
  - List = {1:L5, 2:L2, 4:L3, 25:L1}, `count` = 4.
  - `done` in cycle 16 (21 with `KNN_PIPE_EN`).
- Tie: test (0,0); points (1,0) L7 at index 0, then (0,1) L9 at index 1 -> entry0 = 1:L7, entry1 = 1:L9.
- Extremes: test (−32768,−32768), single point (32767,32767) -> `rd_dist` = 8 589 672 450, no wrap.
- Short scan: n = 2 -> `count` = 2; entries 2 and 3 have `rd_valid` = 0 and dist all-ones. n = 0 -> `done` 1 cycle after `start`; `mem_req` never asserted.
- Handshake:
  - Ack delayed 3 cycles -> `mem_addr` stable and `mem_req` high throughout; total latency +3 per delayed point.
  - `start` pulsed while busy -> ignored.
- Reset: `rst` low during INSERT of point 3 -> all outputs at reset values next cycle. A following scan gives a correct list.
